fifo_wr_packer: RTL
===================

Name: fifo_wr_packer

Overview:
Write-side feeder for the async FIFO. It sits directly upstream of the write-pointer/full-flag stage and the FIFO memory write port. It accepts a narrow valid/ready beat stream and packs PACK beats into one wide FIFO word. It drives winc/wdata only when the FIFO is not full, so no word is ever dropped. A packet end (in_last) flushes a partial word with a lane-valid mask.

Parameters:
IN_WIDTH, 8, width of one input beat (lane)
PACK, 4, beats per FIFO word; power of two, >= 2
CNT_WIDTH, 16, width of the written-word counter

Ports:
wclk  input  1  write-domain clock
rst  input  1  reset, synchronous, active-high
in_data  input  IN_WIDTH  input beat
in_valid  input  1  beat valid
in_last  input  1  final beat of packet; qualified by in_valid
in_ready  output  1  beat accepted when in_valid & in_ready
full  input  1  registered full flag from the write-pointer stage
winc  output  1  FIFO write strobe
wdata  output  PACK*IN_WIDTH  packed word; lane i at bits [i*IN_WIDTH +: IN_WIDTH]
wkeep  output  PACK  lane-valid mask for wdata
wlast  output  1  word contains end of packet
word_count  output  CNT_WIDTH  total words written (winc pulses), wraps

Behaviour:
- Interface: one clock (wclk); reset rst is synchronous, active-high.
- Two storage stages: an assembly register (asm_data, asm_keep, asm_last, lane index, asm_full) and an output holding register (out_data, out_keep, out_last, out_valid).
- Reset values: in_ready=1, winc=0, wdata=0, wkeep=0, wlast=0, word_count=0, lane=0, asm_full=0, out_valid=0.
- Reset mid-operation clears both stages. Any partial or held word is discarded without a write.
- Accept:
  - A beat is written into lane `lane` of asm_data, and asm_keep[lane] is set.
  - If lane==PACK-1 or in_last: asm_full<=1, asm_last<=in_last, lane<=0.
  - Otherwise lane<=lane+1.
- Move:
  - move = asm_full & (~out_valid | winc).
  - On move, the out register loads the asm contents, out_valid<=1, and the asm stage clears (data, keep, and last to 0).
  - Lanes not written hold 0 in wdata and 0 in wkeep.
- in_ready = ~asm_full | move (combinational). Sustains one beat per cycle when the FIFO is not full.
- Write:
  - winc = out_valid & ~full (combinational).
  - wdata, wkeep, and wlast are driven from the out register; they read 0 when out_valid=0.
  - On a winc cycle without move: out_valid<=0.
  - With move: the register reloads, out_valid stays 1.
  - The full flag is computed by the write-pointer stage from its next pointer, so it asserts the cycle after the filling write. Gating winc with current full is therefore exact.
- Latency: final beat of a word accepted at edge N → out_valid from edge N+1 → winc in cycle N+1 after edge, if out was free and full=0. This gives 2 edges from beat capture to the write edge.
- Backpressure: while full=1, out holds and the asm stage fills, then in_ready drops. At most PACK+PACK beats are absorbed before in_ready=0.
- Simultaneous events:
  - Final beat accepted while move occurs is impossible, since move requires asm_full and accept then requires move. The beat goes into the freshly cleared asm stage in the same cycle as the move.
  - The assembly update must take priority over the clear for that lane set.
- in_last on lane PACK-1: a normal full word with wlast=1 and wkeep all ones.
- in_last on lane 0: a word with wkeep=1 (only bit 0 set).
- word_count increments on every winc and wraps modulo 2^CNT_WIDTH.

Decomposition:
- Shared package fifo_pkg holds:
  - the clog2 helper for the lane index width (LANE_W = clog2(PACK));
  - default IN_WIDTH/PACK constants;
  - a packed struct type for {data, keep, last} used by both stages.
- One natural sub-module: wr_hold_reg, the single-entry output holding register with load/drain and the winc gating.

Test Plan:
- Reset then stream 8 beats 0x01..0x08 (in_last on 0x08), full=0 → two winc pulses; wdata=0x04030201 then 0x08070605, wkeep=0xF both, wlast=0 then 1; word_count=2.
- Packet of 3 beats 0xAA,0xBB,0xCC with last → one write, wdata=0x00CCBBAA, wkeep=0x7, wlast=1.
- Single-beat packet 0x5A → wdata=0x0000005A, wkeep=0x1, wlast=1, winc exactly 2 edges after capture.
- Hold full=1 while streaming → exactly 8 beats accepted, then in_ready=0, winc=0. Release full → two back-to-back winc cycles, in_ready returns to 1, no data loss or reorder.
- Continuous stream of 40 beats with full=0 → in_ready stays 1 throughout; 10 writes on every 4th cycle; word_count=10.
- Assert rst for one cycle with 2 beats in asm and one word held → all outputs return to reset values, no winc, the next packet packs from lane 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants, lane-index width helper and word layout for the write-side FIFO feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_pkg;

    localparam int IN_WIDTH_DEF = 8;
    localparam int PACK_DEF     = 4;

    // Smallest r with 2**r >= v; a lane index for PACK lanes needs clog2(PACK) bits.
    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

    // Word layout at the default configuration: packed lanes, lane-valid mask, end-of-packet flag.
    typedef struct packed {
        logic [PACK_DEF*IN_WIDTH_DEF-1:0] data;
        logic [PACK_DEF-1:0]              keep;
        logic                             last;
    } word_t;

endpackage

// File: rtl/wr_hold_reg.sv
// Single-entry output holding register feeding the FIFO write port; gates winc with full.
// Latency: a word loaded at edge N is presented (and written if full=0) in the cycle after edge N.
// Backpressure: holds the word while full=1; may reload on the same edge it drains.
module wr_hold_reg
    import fifo_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int KEEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic [KEEP_W-1:0] load_keep,
    input  logic              load_last,
    input  logic              full,
    output logic              winc,
    output logic              valid,
    output logic [WORD_W-1:0] wdata,
    output logic [KEEP_W-1:0] wkeep,
    output logic              wlast
);

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } hold_t;

    hold_t held;

    // full is computed from the write stage's next pointer, so gating with the current flag is exact.
    assign winc = valid & ~full;

    // Load takes priority over drain so a simultaneous write+reload keeps valid asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            held  <= '0;
        end else if (load) begin
            valid     <= 1'b1;
            held.data <= load_data;
            held.keep <= load_keep;
            held.last <= load_last;
        end else if (winc) begin
            valid <= 1'b0;
        end
    end

    assign wdata = valid ? held.data : '0;
    assign wkeep = valid ? held.keep : '0;
    assign wlast = valid ? held.last : 1'b0;

endmodule

// File: rtl/fifo_wr_packer.sv
// Packs PACK narrow beats into one FIFO word; in_last flushes a partial word with a lane mask.
// Latency: final beat captured at edge N is written at edge N+2 when the out stage is free and full=0.
// Backpressure: while full=1 up to 2*PACK beats are absorbed, then in_ready drops; no word is dropped.
module fifo_wr_packer
    import fifo_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int PACK      = PACK_DEF,
    parameter int CNT_WIDTH = 16
) (
    input  logic                     wclk,
    input  logic                     rst,
    input  logic [IN_WIDTH-1:0]      in_data,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    input  logic                     full,
    output logic                     winc,
    output logic [PACK*IN_WIDTH-1:0] wdata,
    output logic [PACK-1:0]          wkeep,
    output logic                     wlast,
    output logic [CNT_WIDTH-1:0]     word_count
);

    localparam int LANE_W = clog2(PACK);
    localparam int WORD_W = PACK * IN_WIDTH;

    logic [WORD_W-1:0] asm_data;
    logic [PACK-1:0]   asm_keep;
    logic              asm_last;
    logic [LANE_W-1:0] lane;
    logic              asm_full;

    logic out_valid;
    logic move;
    logic accept;
    logic lane_end;

    // A completed word advances when the out stage is empty or draining this cycle.
    assign move     = asm_full & (~out_valid | winc);
    assign in_ready = ~asm_full | move;
    assign accept   = in_valid & in_ready;
    assign lane_end = (lane == LANE_W'(PACK - 1)) | in_last;

    // Assembly stage: the clear on move comes first so a beat accepted in the same cycle lands on top of it.
    always_ff @(posedge wclk) begin
        if (rst) begin
            asm_data <= '0;
            asm_keep <= '0;
            asm_last <= 1'b0;
            asm_full <= 1'b0;
            lane     <= '0;
        end else begin
            if (move) begin
                asm_data <= '0;
                asm_keep <= '0;
                asm_last <= 1'b0;
                asm_full <= 1'b0;
            end
            if (accept) begin
                asm_data[lane*IN_WIDTH +: IN_WIDTH] <= in_data;
                asm_keep[lane]                      <= 1'b1;
                if (lane_end) begin
                    asm_full <= 1'b1;
                    asm_last <= in_last;
                    lane     <= '0;
                end else begin
                    lane <= lane + 1'b1;
                end
            end
        end
    end

    wr_hold_reg #(
        .WORD_W (WORD_W),
        .KEEP_W (PACK)
    ) u_hold (
        .clk       (wclk),
        .rst       (rst),
        .load      (move),
        .load_data (asm_data),
        .load_keep (asm_keep),
        .load_last (asm_last),
        .full      (full),
        .winc      (winc),
        .valid     (out_valid),
        .wdata     (wdata),
        .wkeep     (wkeep),
        .wlast     (wlast)
    );

    // Count every write strobe; wraps naturally at 2**CNT_WIDTH.
    always_ff @(posedge wclk) begin
        if (rst) begin
            word_count <= '0;
        end else if (winc) begin
            word_count <= word_count + 1'b1;
        end
    end

endmodule
